// File: rtl/sintetizador_pkg.sv
// rtl/sintetizador_pkg.sv - shared constants and types for the synthesizer voice path
//
// Voice-bus dimensions shared with mapeamento_tecla_cp and instrumento, the
// accumulator width rule, and the mixer FSM state type.
package sintetizador_pkg;

   localparam int N_VOZES   = 10;
   localparam int W_AMOSTRA = 8;

   // A sum of n unsigned w-bit values fits in w + clog2(n) bits.
   function automatic int largura_acc(input int n_vozes, input int w_amostra);
      return w_amostra + $clog2(n_vozes);
   endfunction

   localparam int W_ACC = largura_acc(N_VOZES, W_AMOSTRA);

   typedef enum logic [1:0] {
      OCIOSO,
      ACUM,
      ESCALA,
      ESCREVE
   } estado_t;

endpackage

// File: rtl/gerador_pwm.sv
// rtl/gerador_pwm.sv - frame counter, double-buffered duty and registered PWM comparator
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   duty_prox_i       duty computed for the next frame
//   inicio_quadro_o   high on the last cycle of a frame (next edge is the frame start)
//   pwm_o             registered PWM bit
//   quadro_o          high while the counter is 0
//   nivel_o           duty currently in effect
module gerador_pwm #(
   parameter int W_PWM = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W_PWM-1:0] duty_prox_i,
   output logic             inicio_quadro_o,
   output logic             pwm_o,
   output logic             quadro_o,
   output logic [W_PWM-1:0] nivel_o
);

   logic [W_PWM-1:0] cnt_q;
   logic [W_PWM-1:0] cnt_d;
   logic [W_PWM-1:0] duty_ativo_q;
   logic             pwm_q;
   logic             quadro_q;

   assign cnt_d           = cnt_q + W_PWM'(1);
   assign inicio_quadro_o = (cnt_q == '1);

   // quadro is registered so it stays low through reset even though cnt is 0.
   // The comparator at cnt=2^W_PWM-1 still sees the old duty, which is always
   // a "low" result, so the output is low at cnt=0 whatever the duty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         duty_ativo_q <= '0;
         pwm_q        <= 1'b0;
         quadro_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         quadro_q <= inicio_quadro_o;
         pwm_q    <= (cnt_q < duty_ativo_q);
         if (inicio_quadro_o) begin
            duty_ativo_q <= duty_prox_i;
         end
      end
   end

   assign pwm_o    = pwm_q;
   assign quadro_o = quadro_q;
   assign nivel_o  = duty_ativo_q;

endmodule

// File: rtl/mixador_pwm.sv
// rtl/mixador_pwm.sv - per-frame voice mixer with saturation feeding a PWM audio output
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   amostras     unsigned sample of each voice
//   teclas       active-voice mask (1 = mixed)
//   pwm_out      registered PWM audio bit
//   nivel        duty in effect for the current frame
//   quadro       high during cnt=0
//   saturou      last computed mix was clamped
module mixador_pwm #(
   parameter int N_VOZES   = sintetizador_pkg::N_VOZES,
   parameter int W_AMOSTRA = sintetizador_pkg::W_AMOSTRA,
   parameter int W_PWM     = 8,
   parameter int SHIFT     = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [N_VOZES-1:0][W_AMOSTRA-1:0] amostras,
   input  logic [N_VOZES-1:0]                teclas,
   output logic                              pwm_out,
   output logic [W_PWM-1:0]                  nivel,
   output logic                              quadro,
   output logic                              saturou
);

   import sintetizador_pkg::*;

   localparam int W_ACC_L = largura_acc(N_VOZES, W_AMOSTRA);
   localparam int W_IDX   = (N_VOZES > 1) ? $clog2(N_VOZES) : 1;
   // Comparison width large enough for both the shifted sum and the duty ceiling.
   localparam int W_X     = (W_ACC_L > W_PWM) ? W_ACC_L : W_PWM;
   localparam logic [W_X-1:0]   MAX_DUTY = W_X'((64'd1 << W_PWM) - 64'd1);
   localparam logic [W_IDX-1:0] IDX_ULT  = W_IDX'(N_VOZES - 1);

   estado_t                           estado_q, estado_d;
   logic [W_IDX-1:0]                  idx_q, idx_d;
   logic [W_ACC_L-1:0]                acc_q, acc_d;
   logic [W_PWM-1:0]                  esc_q, esc_d;
   logic                              sat_q, sat_d;
   logic [W_PWM-1:0]                  duty_prox_q, duty_prox_d;
   logic                              saturou_q, saturou_d;
   logic [N_VOZES-1:0][W_AMOSTRA-1:0] snap_amostras_q;
   logic [N_VOZES-1:0]                snap_teclas_q;

   logic                              inicio_quadro;
   logic [W_ACC_L-1:0]                parcela;
   logic [W_X-1:0]                    desl;

   gerador_pwm #(
      .W_PWM (W_PWM)
   ) u_gerador (
      .clk             (clk),
      .rst_n           (rst_n),
      .duty_prox_i     (duty_prox_q),
      .inicio_quadro_o (inicio_quadro),
      .pwm_o           (pwm_out),
      .quadro_o        (quadro),
      .nivel_o         (nivel)
   );

   assign parcela = snap_teclas_q[idx_q] ? W_ACC_L'(snap_amostras_q[idx_q]) : '0;
   assign desl    = W_X'(acc_q >> SHIFT);

   // The FSM finishes by cnt=N_VOZES+1, well before the next frame start, so
   // OCIOSO is the only state that ever sees inicio_quadro.
   always_comb begin
      estado_d    = estado_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      esc_d       = esc_q;
      sat_d       = sat_q;
      duty_prox_d = duty_prox_q;
      saturou_d   = saturou_q;
      case (estado_q)
         OCIOSO: begin
            if (inicio_quadro) begin
               estado_d = ACUM;
               idx_d    = '0;
               acc_d    = '0;
            end
         end
         ACUM: begin
            acc_d = acc_q + parcela;
            if (idx_q == IDX_ULT) begin
               estado_d = ESCALA;
            end else begin
               idx_d = idx_q + W_IDX'(1);
            end
         end
         ESCALA: begin
            if (desl > MAX_DUTY) begin
               esc_d = '1;
               sat_d = 1'b1;
            end else begin
               esc_d = desl[W_PWM-1:0];
               sat_d = 1'b0;
            end
            estado_d = ESCREVE;
         end
         ESCREVE: begin
            duty_prox_d = esc_q;
            saturou_d   = sat_q;
            estado_d    = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q        <= OCIOSO;
         idx_q           <= '0;
         acc_q           <= '0;
         esc_q           <= '0;
         sat_q           <= 1'b0;
         duty_prox_q     <= '0;
         saturou_q       <= 1'b0;
         snap_amostras_q <= '0;
         snap_teclas_q   <= '0;
      end else begin
         estado_q    <= estado_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         esc_q       <= esc_d;
         sat_q       <= sat_d;
         duty_prox_q <= duty_prox_d;
         saturou_q   <= saturou_d;
         if (inicio_quadro) begin
            snap_amostras_q <= amostras;
            snap_teclas_q   <= teclas;
         end
      end
   end

   assign saturou = saturou_q;

endmodule

// File: tb/tb_mixador_pwm.sv
// tb/tb_mixador_pwm.sv - self-checking bench for mixador_pwm
module tb_mixador_pwm;

   localparam int N   = 10;
   localparam int WA  = 8;
   localparam int WP  = 8;
   localparam int SH  = 2;
   localparam int PER = 256;

   typedef logic [N-1:0][WA-1:0] vet_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   vet_t          amostras = '0;
   logic [N-1:0]  teclas = '0;
   logic          pwm_out;
   logic [WP-1:0] nivel;
   logic          quadro;
   logic          saturou;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mixador_pwm #(
      .N_VOZES   (N),
      .W_AMOSTRA (WA),
      .W_PWM     (WP),
      .SHIFT     (SH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .amostras (amostras),
      .teclas   (teclas),
      .pwm_out  (pwm_out),
      .nivel    (nivel),
      .quadro   (quadro),
      .saturou  (saturou)
   );

   function automatic void modelo(input vet_t a, input logic [N-1:0] m,
                                  output int duty, output bit sat);
      int soma = 0;
      int esc;
      for (int i = 0; i < N; i++) begin
         if (m[i]) soma += int'(a[i]);
      end
      esc  = soma >> SH;
      sat  = (esc > PER - 1);
      duty = sat ? PER - 1 : esc;
   endfunction

   task automatic esperar_quadro(input string nome);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!quadro && n < 600);
      checks++;
      if (quadro !== 1'b1) begin
         errors++;
         $display("FAIL %s: quadro not seen after %0d cycles", nome, n);
      end
   endtask

   task automatic test_reset();
      int n = 0;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pwm_out, nivel, quadro, saturou} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got pwm=%b nivel=%0d quadro=%b sat=%b want all 0",
                  pwm_out, nivel, quadro, saturou);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!quadro && n < 600);
      checks++;
      if (n != PER) begin
         errors++;
         $display("FAIL reset_first_quadro: got %0d cycles want %0d", n, PER);
      end
   endtask

   // Full scenario: inputs snapshotted at frame F, saturou checked at cnt=12
   // of F, whole PWM waveform of frame F+1 checked against the model.
   task automatic test_mix(input string nome, input vet_t a, input logic [N-1:0] m);
      int d;
      bit s;
      int altos = 0;
      int primeiro = -1;
      int ultimo = -1;
      bit nivel_ok = 1'b1;
      bit baixo0;
      modelo(a, m, d, s);
      amostras = a;
      teclas   = m;
      esperar_quadro(nome);
      repeat (12) @(negedge clk);
      checks++;
      if (saturou !== s) begin
         errors++;
         $display("FAIL %s_saturou: got %b want %b", nome, saturou, s);
      end
      esperar_quadro(nome);
      baixo0 = (pwm_out === 1'b0);
      for (int k = 0; k < PER; k++) begin
         if (k > 0) @(negedge clk);
         if (pwm_out === 1'b1) begin
            altos++;
            if (primeiro < 0) primeiro = k;
            ultimo = k;
         end
         if (nivel !== WP'(d)) nivel_ok = 1'b0;
      end
      checks++;
      if (!nivel_ok) begin
         errors++;
         $display("FAIL %s_nivel: got %0d want %0d", nome, nivel, d);
      end
      checks++;
      if (altos != d) begin
         errors++;
         $display("FAIL %s_high_count: got %0d want %0d", nome, altos, d);
      end
      checks++;
      if (!baixo0) begin
         errors++;
         $display("FAIL %s_low_at_cnt0: got high want low", nome);
      end
      if (d > 0) begin
         checks++;
         if (primeiro != 1 || ultimo != d) begin
            errors++;
            $display("FAIL %s_high_window: got cnt %0d..%0d want 1..%0d", nome, primeiro, ultimo, d);
         end
      end
   endtask

   task automatic test_single_voice();
      vet_t a = '0;
      a[0] = 8'd200;
      test_mix("single_voice", a, 10'b0000000001);
   endtask

   task automatic test_two_voices();
      vet_t a;
      for (int i = 0; i < N; i++) a[i] = 8'd255;
      a[3] = 8'd100;
      a[9] = 8'd60;
      test_mix("two_voices", a, 10'b1000001000);
   endtask

   task automatic test_saturation();
      vet_t a;
      for (int i = 0; i < N; i++) a[i] = 8'd255;
      test_mix("saturation", a, '1);
   endtask

   task automatic test_mask_zero();
      vet_t a;
      for (int i = 0; i < N; i++) a[i] = 8'(i * 20 + 7);
      test_mix("mask_zero", a, '0);
   endtask

   task automatic test_reset_mid_acum();
      int n = 0;
      esperar_quadro("reset_mid");
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pwm_out, nivel, quadro, saturou} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got pwm=%b nivel=%0d quadro=%b sat=%b want all 0",
                  pwm_out, nivel, quadro, saturou);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({pwm_out, nivel, quadro, saturou} !== '0) begin
         errors++;
         $display("FAIL reset_mid_hold: got pwm=%b nivel=%0d quadro=%b sat=%b want all 0",
                  pwm_out, nivel, quadro, saturou);
      end
      rst_n = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!quadro && n < 600);
      checks++;
      if (n != PER) begin
         errors++;
         $display("FAIL reset_mid_first_quadro: got %0d cycles want %0d", n, PER);
      end
      checks++;
      if (nivel !== '0) begin
         errors++;
         $display("FAIL reset_mid_nivel: got %0d want 0", nivel);
      end
   endtask

   task automatic test_snapshot_isolation();
      vet_t a = '0;
      a[0] = 8'd200;
      amostras = a;
      teclas   = 10'b0000000001;
      esperar_quadro("isolation");
      repeat (3) @(negedge clk);
      amostras[0] = 8'd40;
      esperar_quadro("isolation");
      checks++;
      if (nivel !== 8'd50) begin
         errors++;
         $display("FAIL isolation_first: got %0d want 50", nivel);
      end
      esperar_quadro("isolation");
      checks++;
      if (nivel !== 8'd10) begin
         errors++;
         $display("FAIL isolation_second: got %0d want 10", nivel);
      end
   endtask

   task automatic test_random();
      vet_t a;
      logic [N-1:0] m;
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < N; i++) a[i] = 8'($urandom_range(0, 255));
         m = (it == 2) ? '1 : N'($urandom);
         test_mix($sformatf("random%0d", it), a, m);
      end
   endtask

   initial begin
      test_reset();
      test_single_voice();
      test_two_voices();
      test_saturation();
      test_reset_mid_acum();
      test_mask_zero();
      test_snapshot_isolation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
